div_32b_arbiter: RTL and testbench
==================================

// Module: div_32b_arbiter
// PURPOSE
//  Shares one div_32b signed divider among NREQ requesters.
//  - Round-robin arbitration; one operation in flight at a time.
//  - Sequences the divider: single-cycle in_valid pulse, then waits for out_valid or in_error.
//  - Returns Q/R/error to the granted requester over a valid/ready response channel.
// PARAMETERS
//  NREQ     4    number of requesters (2..8)
//  DATA_W   32   operand/result width; must match the divider
//  TIMEOUT  64   WAIT-state cycle limit; used only with DIVARB_TIMEOUT_EN
// PORTS
//  clk            in   1              single clock, rising edge
//  rst            in   1              asynchronous, active-low reset
//  req_valid      in   NREQ           per-requester operation request
//  req_ready      out  NREQ           one-hot accept, asserted only in IDLE
//  req_x          in   NREQ*DATA_W    signed dividends, requester i at [i*DATA_W +: DATA_W]
//  req_y          in   NREQ*DATA_W    signed divisors, same packing
//  rsp_valid      out  NREQ           one-hot response valid
//  rsp_ready      in   NREQ           per-requester response accept
//  rsp_q          out  DATA_W         quotient (shared bus, qualified by rsp_valid)
//  rsp_r          out  DATA_W         remainder
//  rsp_err        out  1              1 = divide-by-zero or timeout
//  div_x          out  DATA_W         to divider X
//  div_y          out  DATA_W         to divider Y
//  div_in_valid   out  1              to divider in_valid
//  div_q          in   DATA_W         from divider Q
//  div_r          in   DATA_W         from divider R
//  div_out_valid  in   1              from divider out_valid
//  div_in_error   in   1              from divider in_error
// BEHAVIOUR
//  Reset values:
//  - FSM = IDLE.
//  - rr pointer = 0.
//  - All outputs 0, including req_ready, rsp_valid, div_in_valid, div_x, div_y, rsp_q, rsp_r, rsp_err.
//  FSM states:
//  - IDLE: req_ready = grant (one-hot, combinational from req_valid and rr pointer); 0 if no request.
//    On req_valid[g] & req_ready[g], latch g, req_x[g] and req_y[g] into div_x/div_y; go to ISSUE.
//  - ISSUE: div_in_valid = 1 for exactly one cycle; go to WAIT.
//  - WAIT: complete on the first cycle with div_out_valid | div_in_error.
//    Both high in the same cycle: treat as error.
//    Normal completion: rsp_q = div_q, rsp_r = div_r, rsp_err = 0.
//    Error completion: rsp_q = {DATA_W{1'b1}}, rsp_r = latched x, rsp_err = 1.
//    Go to RESP.
//  - RESP: rsp_valid[g] = 1; hold rsp_q/rsp_r/rsp_err stable until rsp_ready[g].
//    On that handshake: rr pointer = (g+1) mod NREQ; go to IDLE.
//  Arbitration and timing:
//  - Fairness: the search starts at the rr pointer.
//  - Requests arriving outside IDLE wait; req_ready stays 0 in ISSUE, WAIT and RESP.
//  - Requester-side latency = divider latency + 3 cycles (accept, ISSUE, WAIT sample -> RESP).
//  - A back-to-back request is accepted on the cycle after the RESP handshake.
//  - div_x/div_y stay constant from the accept until the next accept.
//  Reset asserted mid-operation:
//  - Immediate abort; FSM returns to IDLE; response is lost.
//  - The divider shares rst, so it is cleared as well.
// CONFIGURATION
//  DIVARB_TIMEOUT_EN defined:
//  - A counter cleared on entry to WAIT increments every WAIT cycle.
//  - If it reaches TIMEOUT before completion, complete with the error values; go to RESP.
//  - A late div_out_valid arriving after that is ignored.
//  DIVARB_TIMEOUT_EN undefined:
//  - No counter; WAIT persists until the divider responds.
// STRUCTURE
//  Package div_arb_pkg:
//  - state enum IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3.
//  - DATA_W default and error-quotient constant.
//  Sub-module rr_arbiter #(NREQ):
//  - Inputs: req vector, pointer.
//  - Output: one-hot grant plus binary grant index (combinational).
//  FSM, operand/result registers and timeout counter live in div_32b_arbiter.
// TESTING
//  Bench instantiates div_32b_arbiter + div_32b; checks against $signed / and %.
//  1. Single op: req0 x=100, y=7 -> rsp_valid[0], q=14, r=2, err=0.
//  2. Signed op: req2 x=-100, y=7 -> q=-14 (32'hFFFFFFF2), r=-2, err=0.
//  3. Divide by zero: req1 x=55, y=0 -> rsp_valid[1], q=32'hFFFFFFFF, r=55, err=1.
//  4. Contention: req0..3 valid together, pointer 0 -> grant order 0,1,2,3,0.
//     No requester served twice while another waits.
//  5. Backpressure: rsp_ready[0] low 10 cycles -> rsp_q/r stable; req_ready stays 0; no new issue.
//  6. Abort: rst low during WAIT -> all outputs 0 next edge; a fresh op then completes correctly.
//     With DIVARB_TIMEOUT_EN and out_valid forced low -> err=1 after TIMEOUT cycles.

Source files
------------

// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared types and constants for the div_32b divider arbiter.
package div_arb_pkg;

    // Arbiter FSM states; encoding is visible on the debug state port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Operand/result width of the div_32b divider.
    localparam int DIV_DATA_W = 32;

    // Fill bit for the quotient returned on an error completion (all ones).
    localparam logic ERR_Q_FILL = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant. The search starts at ptr_i and
// wraps; the first active request wins. Outputs a one-hot grant and its index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o
);

    // Scan NREQ candidates starting at the pointer; stop at the first request.
    always_comb begin : p_scan
        logic          found;
        int            cand;
        logic [IW-1:0] ci;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        ci      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr_i) + k) % NREQ;
            ci   = cand[IW-1:0];
            if (!found && req_i[ci]) begin
                grant_o[ci] = 1'b1;
                idx_o       = ci;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_32b_arbiter.sv
// div_32b_arbiter: shares one div_32b signed divider among NREQ requesters.
// Round-robin accept, one operation in flight, single-cycle divider issue,
// result returned on a per-requester valid/ready response channel.
// Optional feature: define DIVARB_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT cycles (completes with the error values on expiry).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is one-hot and only ever high in IDLE; the requester
// keeps req_valid/req_x/req_y stable until it sees its ready. rsp_valid is
// one-hot to the granted requester and rsp_q/rsp_r/rsp_err stay constant until
// the matching rsp_ready is sampled high.
module div_32b_arbiter
    import div_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DATA_W  = DIV_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_x,
    input  logic [NREQ*DATA_W-1:0] req_y,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]      rsp_q,
    output logic [DATA_W-1:0]      rsp_r,
    output logic                   rsp_err,
    output logic [DATA_W-1:0]      div_x,
    output logic [DATA_W-1:0]      div_y,
    output logic                   div_in_valid,
    input  logic [DATA_W-1:0]      div_q,
    input  logic [DATA_W-1:0]      div_r,
    input  logic                   div_out_valid,
    input  logic                   div_in_error,
    output logic [1:0]             dbg_state_o
);

    localparam int            IW   = $clog2(NREQ);
    localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("div_32b_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
    end

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [DATA_W-1:0] x_q, x_d, y_q, y_d;
    logic [DATA_W-1:0] q_q, q_d, r_q, r_d;
    logic              err_q, err_d;
    logic [NREQ-1:0]   arb_grant;
    logic [IW-1:0]     arb_idx;
    logic              timeout_hit;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (rr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx)
    );

`ifdef DIVARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // WAIT-cycle counter: zeroed in ISSUE so it starts at 0 on WAIT entry.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ISSUE) begin
            cnt_d = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the TIMEOUT-th WAIT cycle without a divider response.
    assign timeout_hit = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state, operand capture and result capture.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gidx_d  = gidx_q;
        x_d     = x_q;
        y_d     = y_q;
        q_d     = q_q;
        r_d     = r_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (|(req_valid & req_ready)) begin
                    gidx_d  = arb_idx;
                    x_d     = req_x[int'(arb_idx)*DATA_W +: DATA_W];
                    y_d     = req_y[int'(arb_idx)*DATA_W +: DATA_W];
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // Error wins when error and out_valid coincide.
                if (div_in_error || timeout_hit) begin
                    q_d     = {DATA_W{ERR_Q_FILL}};
                    r_d     = x_q;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (div_out_valid) begin
                    q_d     = div_q;
                    r_d     = div_r;
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[gidx_q]) begin
                    rr_d    = (gidx_q == LAST) ? '0 : gidx_q + IW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer and datapath registers; reset aborts any operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gidx_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gidx_q  <= gidx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            q_q     <= q_d;
            r_q     <= r_d;
            err_q   <= err_d;
        end
    end

    // Response valid goes only to the requester that was granted.
    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) begin
            rsp_valid[gidx_q] = 1'b1;
        end
    end

    // Ready is gated by reset so every output is 0 while reset is held.
    assign req_ready    = (rst && state_q == IDLE) ? arb_grant : '0;
    assign div_in_valid = (state_q == ISSUE);
    assign div_x        = x_q;
    assign div_y        = y_q;
    assign rsp_q        = q_q;
    assign rsp_r        = r_q;
    assign rsp_err      = err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_div_32b_arbiter.sv
// tb_div_32b_arbiter: directed bench for div_32b_arbiter with a behavioural
// fixed-latency signed divider standing in for div_32b.
module tb_div_32b_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int LAT  = 4;   // divider: in_valid edge to out_valid edge
    localparam int TOUT = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NREQ-1:0]  req_valid = '0;
    logic [NREQ-1:0]  req_ready;
    logic [NREQ*DW-1:0] req_x = '0;
    logic [NREQ*DW-1:0] req_y = '0;
    logic [NREQ-1:0]  rsp_valid;
    logic [NREQ-1:0]  rsp_ready = '0;
    logic [DW-1:0]    rsp_q, rsp_r;
    logic             rsp_err;
    logic [DW-1:0]    div_x, div_y;
    logic             div_in_valid;
    logic [DW-1:0]    div_q, div_r;
    logic             div_out_valid, div_in_error;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic hold_off = 1'b0;   // divider swallows the result when set

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    div_32b_arbiter #(
        .NREQ    (NREQ),
        .DATA_W  (DW),
        .TIMEOUT (TOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_x         (req_x),
        .req_y         (req_y),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_q         (rsp_q),
        .rsp_r         (rsp_r),
        .rsp_err       (rsp_err),
        .div_x         (div_x),
        .div_y         (div_y),
        .div_in_valid  (div_in_valid),
        .div_q         (div_q),
        .div_r         (div_r),
        .div_out_valid (div_out_valid),
        .div_in_error  (div_in_error),
        .dbg_state_o   (dbg_state)
    );

    // ---------------- divider model ----------------
    int         dcnt;
    logic       dbusy;
    logic [DW-1:0] dx, dy;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbusy <= 1'b0; dcnt <= 0; dx <= '0; dy <= '0;
            div_out_valid <= 1'b0; div_in_error <= 1'b0;
            div_q <= '0; div_r <= '0;
        end else begin
            div_out_valid <= 1'b0;
            div_in_error  <= 1'b0;
            if (div_in_valid) begin
                dbusy <= 1'b1; dcnt <= LAT; dx <= div_x; dy <= div_y;
            end else if (dbusy) begin
                if (dcnt == 1) begin
                    dbusy <= 1'b0;
                    if (!hold_off) begin
                        if (dy == '0) begin
                            div_in_error <= 1'b1;
                        end else begin
                            div_out_valid <= 1'b1;
                            div_q <= $signed(dx) / $signed(dy);
                            div_r <= $signed(dx) % $signed(dy);
                        end
                    end
                end else begin
                    dcnt <= dcnt - 1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_op(input int idx, input logic [31:0] x, input logic [31:0] y);
        req_x[idx*DW +: DW] = x;
        req_y[idx*DW +: DW] = y;
    endtask

    // Called at posedge+1 with req_valid[idx] high; returns at posedge+1 after accept.
    task automatic wait_accept(input int idx, input string tag);
        int n = 0;
        #2;
        while (!req_ready[idx] && n < 100) begin
            @(posedge clk); #3; n++;
        end
        chk({tag, "_accept"}, {31'b0, req_ready[idx]}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp(output int cycles);
        cycles = 0;
        while (rsp_valid == '0 && cycles < 200) begin
            @(posedge clk); #1; cycles++;
        end
    endtask

    task automatic finish_rsp(input int idx, input logic [31:0] eq, input logic [31:0] er,
                              input logic ee, input string tag);
        chk({tag, "_valid"}, {28'b0, rsp_valid}, 32'd1 << idx);
        chk({tag, "_q"}, rsp_q, eq);
        chk({tag, "_r"}, rsp_r, er);
        chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, ee});
        rsp_ready[idx] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[idx] = 1'b0;
        chk({tag, "_idle"}, {30'b0, dbg_state}, 32'd0);
        chk({tag, "_vdone"}, {28'b0, rsp_valid}, 32'd0);
    endtask

    task automatic do_op(input int idx, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eq, input logic [31:0] er, input logic ee,
                         input string tag, output int lat);
        set_op(idx, x, y);
        req_valid[idx] = 1'b1;
        wait_accept(idx, tag);
        req_valid[idx] = 1'b0;
        wait_rsp(lat);
        finish_rsp(idx, eq, er, ee, tag);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, {28'b0, req_ready}, 32'd0);
        chk({tag, "_rsp_valid"}, {28'b0, rsp_valid}, 32'd0);
        chk({tag, "_in_valid"}, {31'b0, div_in_valid}, 32'd0);
        chk({tag, "_div_x"}, div_x, 32'd0);
        chk({tag, "_div_y"}, div_y, 32'd0);
        chk({tag, "_rsp_q"}, rsp_q, 32'd0);
        chk({tag, "_rsp_r"}, rsp_r, 32'd0);
        chk({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
        chk({tag, "_state"}, {30'b0, dbg_state}, 32'd0);
    endtask

    // Watchdog in case a wait outside the bounded loops stalls.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int g;
        int n;
        int          ord [5]   = '{0, 1, 2, 3, 0};
        logic [31:0] c_q [5]   = '{32'hFFFFFF72, 32'd7, 32'd0, 32'h3FFFFFFF, 32'hFFFFFFFE};
        logic [31:0] c_r [5]   = '{32'd6, 32'hFFFFFFFD, 32'd0, 32'd1, 32'hFFFFFFFF};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        // 1. Single op, plus requester-side latency (accept edge to RESP = LAT+2 edges)
        do_op(0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "single", lat);
        chk("single_latency", lat, LAT + 2);

        // 2. Signed op: -100 / 7 -> q=-14, r=-2
        do_op(2, -32'sd100, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, "signed", lat);

        // 3. Divide by zero: q all ones, r = dividend, err
        do_op(1, 32'd55, 32'd0, 32'hFFFFFFFF, 32'd55, 1'b1, "divzero", lat);

        // 6. Abort during WAIT
        set_op(2, 32'd500, 32'd3);
        req_valid[2] = 1'b1;
        wait_accept(2, "abort");
        req_valid[2] = 1'b0;
        n = 0;
        while (dbg_state != 2'd2 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("abort_in_wait", {30'b0, dbg_state}, 32'd2);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("abort");
        rst = 1'b1;
        @(posedge clk); #1;
        // Fresh op after abort: -7 / 2 -> q=-3, r=-1 (pointer restarts at 0)
        do_op(3, -32'sd7, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, "post_abort", lat);

        // 4. Contention: pointer 0, all requesting, req0 asks twice
        set_op(0, 32'd1000, -32'sd7);
        set_op(1, -32'sd45, -32'sd6);
        set_op(2, 32'd0, 32'd5);
        set_op(3, 32'd2147483647, 32'd2);
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            #2;
            while (req_ready == '0 && n < 100) begin
                @(posedge clk); #3; n++;
            end
            chk($sformatf("rr_grant%0d", k), {28'b0, req_ready}, 32'd1 << ord[k]);
            g = 0;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
            @(posedge clk); #1;
            if (k == 0) set_op(0, -32'sd9, 32'd4);
            else        req_valid[g] = 1'b0;
            wait_rsp(lat);
            finish_rsp(ord[k], c_q[k], c_r[k], 1'b0, $sformatf("rr_op%0d", k));
        end

        // 5. Backpressure: 77 / 10 held 10 cycles while req1 waits; pointer is now 1
        set_op(0, 32'd77, 32'd10);
        req_valid[0] = 1'b1;
        wait_accept(0, "bp");
        req_valid[0] = 1'b0;
        set_op(1, 32'd20, 32'd3);
        req_valid[1] = 1'b1;
        wait_rsp(lat);
        for (int c = 0; c < 10; c++) begin
            chk("bp_valid", {28'b0, rsp_valid}, 32'd1);
            chk("bp_q", rsp_q, 32'd7);
            chk("bp_r", rsp_r, 32'd7);
            chk("bp_req_ready", {28'b0, req_ready}, 32'd0);
            chk("bp_in_valid", {31'b0, div_in_valid}, 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        // Back-to-back: req1 accepted on the cycle after the handshake
        chk("bp_next_ready", {28'b0, req_ready}, 32'd2);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_rsp(lat);
        finish_rsp(1, 32'd6, 32'd2, 1'b0, "bp_next");

`ifdef DIVARB_TIMEOUT_EN
        // Timeout: divider never answers; accept edge to RESP = TIMEOUT+1 edges
        hold_off = 1'b1;
        do_op(2, 32'd9, 32'd3, 32'hFFFFFFFF, 32'd9, 1'b1, "timeout", lat);
        chk("timeout_latency", lat, TOUT + 1);
        hold_off = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
